// File: rtl/cpu_trace_pkg.sv
// ---------------------------------------------------------------------------
// cpu_trace_pkg
// Shared constants for the CPU trace instruction-memory controller.
//   TRC_DEPTH / TRC_AW / TRC_DW : capture buffer geometry (128 x 36).
//   TRC_EN_BIT / TRC_CLR_BIT    : jdo bits decoded on a trace-control write.
//   TRC_RDADDR_LSB              : base of the readback address field in jdo.
// ---------------------------------------------------------------------------
package cpu_trace_pkg;

    localparam int TRC_DEPTH      = 128;
    localparam int TRC_AW         = 7;
    localparam int TRC_DW         = 36;
    localparam int JDO_W          = 38;

    localparam int TRC_EN_BIT     = 0;
    localparam int TRC_CLR_BIT    = 1;
    localparam int TRC_RDADDR_LSB = 0;

    // Decoded readback command after strobe prioritisation.
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_LOAD   = 2'd1,  // load rd_addr from jdo
        RD_INC    = 2'd2,  // read, then advance rd_addr
        RD_REREAD = 2'd3   // read, rd_addr unchanged
    } rd_cmd_e;

endpackage

// File: rtl/cpu_trace_ram.sv
// ---------------------------------------------------------------------------
// cpu_trace_ram
// 128x36 simple dual-port RAM: one write port, one synchronous read port.
// A read and a write to the same address on the same edge return the old
// word (both sides use non-blocking updates of the same array).
// Ports:
//   clk                       : clock
//   wr_en, wr_addr, wr_data   : write port
//   rd_en, rd_addr            : read request, sampled on the rising edge
//   rd_data                   : registered read data, valid after the edge
// Contents are not reset.
// ---------------------------------------------------------------------------
module cpu_trace_ram
    import cpu_trace_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [TRC_AW-1:0] wr_addr,
    input  logic [TRC_DW-1:0] wr_data,
    input  logic              rd_en,
    input  logic [TRC_AW-1:0] rd_addr,
    output logic [TRC_DW-1:0] rd_data
);

    logic [TRC_DW-1:0] mem [TRC_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cpu_trace_im_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_trace_im_ctrl
// Trace capture buffer controller. Captures trace words into a 128-entry RAM
// while enabled and the CPU is not halted, and serves JTAG readback.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   jdo                         : JTAG data word (enable/clear bits, rd addr)
//   take_action_tracectrl       : control write (enable, optional clear)
//   take_action_tracemem_a      : load readback address
//   take_action_tracemem_b      : read current word, then advance address
//   take_no_action_tracemem_a   : re-read current word
//   tw_valid, tw_data           : incoming trace word
//   debugack                    : CPU halted in debug, suspends capture
//   trc_on, tracemem_on         : capture enabled / enabled and running
//   trc_im_addr, trc_wrap       : capture pointer, sticky wrap flag
//   tracemem_trcdata, tracemem_tw : readback word and its one-cycle strobe
// Build option: define CPU_TRACE_STOP_ON_WRAP_EN to stop capture after the
// write at the last address instead of overwriting the oldest entries.
// ---------------------------------------------------------------------------
module cpu_trace_im_ctrl
    import cpu_trace_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_tracectrl,
    input  logic              take_action_tracemem_a,
    input  logic              take_action_tracemem_b,
    input  logic              take_no_action_tracemem_a,
    input  logic              tw_valid,
    input  logic [TRC_DW-1:0] tw_data,
    input  logic              debugack,
    output logic              trc_on,
    output logic              tracemem_on,
    output logic [TRC_AW-1:0] trc_im_addr,
    output logic              trc_wrap,
    output logic [TRC_DW-1:0] tracemem_trcdata,
    output logic              tracemem_tw
);

    rd_cmd_e           rd_cmd;
    logic [TRC_AW-1:0] rd_addr;
    logic [TRC_DW-1:0] ram_q;
    logic              clr;
    logic              cap;
    logic              wrap_hit;
    logic              rd_fire;
    // [0]: RAM read issued this edge; [1]: data registered, tw pulse
    logic [1:0]        vld_pipe;

    // Only the address field and control bits of jdo are meaningful here.
    logic              unused_jdo;
    assign unused_jdo = ^jdo[JDO_W-1:TRC_AW];

    assign tracemem_on = trc_on & ~debugack;
    assign clr         = take_action_tracectrl & jdo[TRC_CLR_BIT];
    // A clear on the same edge wins over the capture.
    assign cap         = tracemem_on & tw_valid & ~clr;
    assign wrap_hit    = cap & (&trc_im_addr);

    always_comb begin
        rd_cmd = RD_NONE;
        if (take_action_tracectrl)
            rd_cmd = RD_NONE;
        else if (take_action_tracemem_a)
            rd_cmd = RD_LOAD;
        else if (take_action_tracemem_b)
            rd_cmd = RD_INC;
        else if (take_no_action_tracemem_a)
            rd_cmd = RD_REREAD;
    end

    // Readback is locked out while capture is enabled.
    assign rd_fire = ((rd_cmd == RD_INC) || (rd_cmd == RD_REREAD)) && !trc_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            trc_on      <= 1'b0;
            trc_im_addr <= '0;
            trc_wrap    <= 1'b0;
        end else begin
            if (take_action_tracectrl)
                trc_on <= jdo[TRC_EN_BIT];
`ifdef CPU_TRACE_STOP_ON_WRAP_EN
            if (wrap_hit)
                trc_on <= 1'b0;
`endif
            if (clr) begin
                trc_im_addr <= '0;
                trc_wrap    <= 1'b0;
            end else if (cap) begin
                // 127 + 1 rolls to 0 in both build variants.
                trc_im_addr <= trc_im_addr + 7'd1;
                if (wrap_hit)
                    trc_wrap <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr          <= '0;
            vld_pipe         <= '0;
            tracemem_trcdata <= '0;
        end else begin
            case (rd_cmd)
                RD_LOAD: rd_addr <= jdo[TRC_RDADDR_LSB +: TRC_AW];
                RD_INC:  if (!trc_on) rd_addr <= rd_addr + 7'd1;
                default: ;
            endcase
            vld_pipe <= {vld_pipe[0], rd_fire};
            if (vld_pipe[0])
                tracemem_trcdata <= ram_q;
        end
    end

    assign tracemem_tw = vld_pipe[1];

    cpu_trace_ram u_ram (
        .clk     (clk),
        .wr_en   (cap),
        .wr_addr (trc_im_addr),
        .wr_data (tw_data),
        .rd_en   (rd_fire),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_cpu_trace_im_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_trace_im_ctrl
// Directed bench for cpu_trace_im_ctrl. Read strobes push the expected word
// and its due cycle into a queue; a negedge monitor pops on every
// tracemem_tw and compares data and timing.
// ---------------------------------------------------------------------------
module tb_cpu_trace_im_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_tracectrl;
    logic        take_action_tracemem_a;
    logic        take_action_tracemem_b;
    logic        take_no_action_tracemem_a;
    logic        tw_valid;
    logic [35:0] tw_data;
    logic        debugack;
    logic        trc_on;
    logic        tracemem_on;
    logic [6:0]  trc_im_addr;
    logic        trc_wrap;
    logic [35:0] tracemem_trcdata;
    logic        tracemem_tw;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [35:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    cpu_trace_im_ctrl dut (
        .clk                       (clk),
        .reset                     (reset),
        .jdo                       (jdo),
        .take_action_tracectrl     (take_action_tracectrl),
        .take_action_tracemem_a    (take_action_tracemem_a),
        .take_action_tracemem_b    (take_action_tracemem_b),
        .take_no_action_tracemem_a (take_no_action_tracemem_a),
        .tw_valid                  (tw_valid),
        .tw_data                   (tw_data),
        .debugack                  (debugack),
        .trc_on                    (trc_on),
        .tracemem_on               (tracemem_on),
        .trc_im_addr               (trc_im_addr),
        .trc_wrap                  (trc_wrap),
        .tracemem_trcdata          (tracemem_trcdata),
        .tracemem_tw               (tracemem_tw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tw pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (tracemem_tw === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_tw: got tw=1 data 0x%0h expected no pulse (cycle %0d)",
                         tracemem_trcdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tw_data", 64'(tracemem_trcdata), 64'(e.data));
                chk("tw_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic [37:0] v);
        jdo = v;
        take_action_tracectrl = 1'b1;
        tick();
        take_action_tracectrl = 1'b0;
    endtask

    task automatic push(input logic [35:0] d);
        tw_valid = 1'b1;
        tw_data  = d;
        tick();
        tw_valid = 1'b0;
    endtask

    task automatic rd_a(input logic [6:0] a);
        jdo = 38'(a);
        take_action_tracemem_a = 1'b1;
        tick();
        take_action_tracemem_a = 1'b0;
    endtask

    // Read with advance; pulse expected two edges after the strobe is driven.
    task automatic rd_b(input logic [35:0] exp);
        exp_t e;
        e.data = exp;
        e.due  = cyc + 2;
        exp_q.push_back(e);
        take_action_tracemem_b = 1'b1;
        tick();
        take_action_tracemem_b = 1'b0;
    endtask

    task automatic rd_na(input logic [35:0] exp);
        exp_t e;
        e.data = exp;
        e.due  = cyc + 2;
        exp_q.push_back(e);
        take_no_action_tracemem_a = 1'b1;
        tick();
        take_no_action_tracemem_a = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_action_tracectrl = 1'b0;
        take_action_tracemem_a = 1'b0;
        take_action_tracemem_b = 1'b0;
        take_no_action_tracemem_a = 1'b0;
        tw_valid = 1'b0;
        tw_data = '0;
        debugack = 1'b0;
        idle(3);
        chk("rst_trc_on", 64'(trc_on), 64'd0);
        chk("rst_addr", 64'(trc_im_addr), 64'd0);
        chk("rst_wrap", 64'(trc_wrap), 64'd0);
        chk("rst_trcdata", 64'(tracemem_trcdata), 64'd0);
        chk("rst_tw", 64'(tracemem_tw), 64'd0);
        reset = 1'b0;
        tick();

        // Capture five words, then read them back in order.
        ctrl(38'h1);
        chk("cap_trc_on", 64'(trc_on), 64'd1);
        chk("cap_tracemem_on", 64'(tracemem_on), 64'd1);
        for (int i = 0; i < 5; i++) push(36'hA00000000 + 36'(i));
        chk("cap_addr", 64'(trc_im_addr), 64'd5);
        chk("cap_wrap", 64'(trc_wrap), 64'd0);
        ctrl(38'h0);
        chk("cap_off", 64'(trc_on), 64'd0);
        rd_a(7'd0);
        for (int i = 0; i < 5; i++) rd_b(36'hA00000000 + 36'(i));
        idle(3);

        // Readback blocked while enabled; rd_addr must not move.
        ctrl(38'h1);
        rd_a(7'd2);
        take_action_tracemem_b = 1'b1;
        tick();
        take_action_tracemem_b = 1'b0;
        idle(3);
        ctrl(38'h0);
        rd_na(36'hA00000002);
        rd_na(36'hA00000002);
        rd_b(36'hA00000002);
        rd_b(36'hA00000003);
        idle(3);
        chk("hold_trcdata", 64'(tracemem_trcdata), 64'hA00000003);

        // Debug halt suspends capture.
        ctrl(38'h1);
        debugack = 1'b1;
        tw_valid = 1'b1;
        tw_data  = 36'hFFFFFFFFF;
        idle(10);
        chk("halt_tracemem_on", 64'(tracemem_on), 64'd0);
        tw_valid = 1'b0;
        debugack = 1'b0;
        chk("halt_addr", 64'(trc_im_addr), 64'd5);

        // Wrap across the whole buffer.
        ctrl(38'h3);
        chk("clr_addr", 64'(trc_im_addr), 64'd0);
        for (int i = 0; i < 127; i++) push(36'hC00000000 + 36'(i));
        chk("pre_wrap_addr", 64'(trc_im_addr), 64'd127);
        chk("pre_wrap_flag", 64'(trc_wrap), 64'd0);
        push(36'hC0000007F);
        chk("wrap_addr", 64'(trc_im_addr), 64'd0);
        chk("wrap_flag", 64'(trc_wrap), 64'd1);
`ifdef CPU_TRACE_STOP_ON_WRAP_EN
        chk("wrap_stop_on", 64'(trc_on), 64'd0);
`endif
        push(36'hC00000080);
        push(36'hC00000081);
`ifdef CPU_TRACE_STOP_ON_WRAP_EN
        chk("wrap_end_addr", 64'(trc_im_addr), 64'd0);
        chk("wrap_end_on", 64'(trc_on), 64'd0);
`else
        chk("wrap_end_addr", 64'(trc_im_addr), 64'd2);
        chk("wrap_end_on", 64'(trc_on), 64'd1);
`endif
        chk("wrap_end_flag", 64'(trc_wrap), 64'd1);
        ctrl(38'h0);
        chk("wrap_flag_sticky", 64'(trc_wrap), 64'd1);
        rd_a(7'd0);
`ifdef CPU_TRACE_STOP_ON_WRAP_EN
        rd_b(36'hC00000000);
        rd_b(36'hC00000001);
`else
        rd_b(36'hC00000080);
        rd_b(36'hC00000081);
`endif
        rd_b(36'hC00000002);
        idle(3);

        // Clear coincident with a capture at address 9.
        ctrl(38'h3);
        for (int i = 0; i < 9; i++) push(36'hD00000000 + 36'(i));
        chk("coll_pre_addr", 64'(trc_im_addr), 64'd9);
        jdo = 38'h3;
        take_action_tracectrl = 1'b1;
        tw_valid = 1'b1;
        tw_data  = 36'hEEEEEEEEE;
        tick();
        take_action_tracectrl = 1'b0;
        tw_valid = 1'b0;
        chk("coll_addr", 64'(trc_im_addr), 64'd0);
        chk("coll_wrap", 64'(trc_wrap), 64'd0);
        chk("coll_on", 64'(trc_on), 64'd1);
        ctrl(38'h0);
        rd_a(7'd9);
        rd_na(36'hC00000009);
        idle(3);

        // Reset the cycle after a read strobe: no pulse, outputs cleared.
        rd_a(7'd0);
        take_action_tracemem_b = 1'b1;
        tick();
        take_action_tracemem_b = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid_rst_tw", 64'(tracemem_tw), 64'd0);
        chk("mid_rst_trcdata", 64'(tracemem_trcdata), 64'd0);
        chk("mid_rst_addr", 64'(trc_im_addr), 64'd0);
        chk("mid_rst_on", 64'(trc_on), 64'd0);
        tick();
        chk("mid_rst_tw2", 64'(tracemem_tw), 64'd0);
        reset = 1'b0;
        tick();
        rd_a(7'd0);
        rd_b(36'hD00000000);
        rd_b(36'hD00000001);
        idle(5);

        chk("pending_reads", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_trace_im_ctrl.md
CPU_TRACE_IM_CTRL -- requirements
Module: cpu_trace_im_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous active-high reset: clk is the sole clock, reset is synchronous and active-high.
REQ-002 SHALL expose ports (name, direction, width, meaning):
- clk, in, 1: sole clock; all state updates on the rising edge.
- reset, in, 1: synchronous active-high reset.
- jdo, in, 38: JTAG debug data word.
- take_action_tracectrl, in, 1: trace-control write strobe.
- take_action_tracemem_a, in, 1: load the readback address.
- take_action_tracemem_b, in, 1: read the current word, then increment the read address.
- take_no_action_tracemem_a, in, 1: re-read the current word, no increment.
- tw_valid, in, 1: trace word present.
- tw_data, in, 36: trace word.
- debugack, in, 1: CPU halted in debug.
- trc_on, out, 1: capture enabled.
- tracemem_on, out, 1: capture enabled and CPU not halted.
- trc_im_addr, out, 7: capture write pointer.
- trc_wrap, out, 1: sticky flag, buffer has wrapped.
- tracemem_trcdata, out, 36: readback word.
- tracemem_tw, out, 1: one-cycle pulse, tracemem_trcdata updated.

Function
REQ-003 SHALL decode the trace-control write (take_action_tracectrl=1) as follows:
- trc_on <= jdo[0].
- If jdo[1]=1: trc_im_addr <= 0 and trc_wrap <= 0.
REQ-004 SHALL drive tracemem_on combinationally as trc_on & ~debugack.
REQ-005 SHALL perform a capture write when tracemem_on=1 and tw_valid=1: write tw_data at trc_im_addr, and trc_im_addr <= trc_im_addr+1 modulo 128.
REQ-006 SHALL set trc_wrap when a capture write occurs at address 127; trc_wrap stays set until cleared by REQ-003 or by reset.
REQ-007 SHALL give clear precedence over capture: a capture write coinciding with a jdo[1]=1 control write is dropped, and the pointer and wrap flag end at 0.
REQ-008 SHALL keep a separate 7-bit read pointer rd_addr, with strobe priority tracectrl > tracemem_a > tracemem_b > no_action_tracemem_a; only the highest-priority asserted strobe acts.
REQ-009 SHALL handle take_action_tracemem_a as: rd_addr <= jdo[6:0]; no read, no tracemem_tw.
REQ-010 SHALL handle take_action_tracemem_b, when trc_on=0, as:
- Read the RAM at rd_addr.
- rd_addr <= rd_addr+1 modulo 128.
- One cycle later, tracemem_trcdata is loaded and tracemem_tw=1 for exactly one cycle.
REQ-011 SHALL handle take_no_action_tracemem_a, when trc_on=0, the same as REQ-010 but without incrementing rd_addr.
REQ-012 SHALL ignore readback strobes (REQ-010, REQ-011) while trc_on=1: no read occurs, rd_addr is unchanged, tracemem_tw stays 0 and tracemem_trcdata holds its value.
REQ-013 SHALL give the pre-write (old) data when a read and a capture write hit the same address in the same cycle.
REQ-014 SHALL hold tracemem_trcdata between reads.

Reset
REQ-015 SHALL, while reset=1, force trc_on=0, trc_im_addr=0, trc_wrap=0, rd_addr=0, tracemem_trcdata=0, tracemem_tw=0.
REQ-016 SHALL give reset priority over all strobes; a read in flight when reset asserts produces no tracemem_tw pulse.
REQ-017 SHALL NOT clear RAM contents on reset.

Configuration
REQ-018 SHALL provide macro CPU_TRACE_STOP_ON_WRAP_EN:
- Defined: a capture write at address 127 sets trc_wrap, returns trc_im_addr to 0 and clears trc_on in the same edge, so no further capture occurs until re-enabled.
- Undefined: capture continues and overwrites the oldest entries; trc_on is unaffected.

Structure
REQ-019 SHALL place in shared package cpu_trace_pkg:
- Constants TRC_DEPTH=128, TRC_AW=7, TRC_DW=36.
- jdo field indices: TRC_EN_BIT=0, TRC_CLR_BIT=1, TRC_RDADDR_LSB=0.
REQ-020 SHALL instantiate one sub-module, cpu_trace_ram: 128x36 simple dual-port RAM, one write port, one synchronous read port, read-old-data on collision.

Verification
REQ-021 SHALL cover, at minimum, these directed scenarios:
- Capture: enable (jdo=0x1), push 5 words 0xA00000000..0xA00000004 -> trc_im_addr=5, trc_wrap=0; disable; load rd_addr=0, issue 5x tracemem_b -> 5 tw pulses, each 1 cycle after its strobe, returning those values in order.
- Wrap: enable, push 130 words -> trc_im_addr=2, trc_wrap=1. With CPU_TRACE_STOP_ON_WRAP_EN: trc_im_addr=0, trc_on=0 after word 128, words 129-130 not written.
- Debug halt: debugack=1 with tw_valid=1 for 10 cycles -> tracemem_on=0, pointer unchanged.
- Clear collision: control write jdo=0x3 coincident with a capture write at addr 9 -> trc_im_addr=0, trc_wrap=0, RAM addr 9 unchanged.
- Read blocked: trc_on=1, issue tracemem_b -> no tw pulse, rd_addr unchanged; no_action_tracemem_a after disable re-reads the same address twice with identical data.
- Reset mid-read: assert reset the cycle after a tracemem_b -> tracemem_tw stays 0, all outputs 0, RAM data still readable afterwards.
